z80_bus_responder: RTL

Synthesizable memory and I/O target for the tv80s core's external bus. It decodes the CPU's `mreq_n`/`iorq_n`/`rd_n`/`wr_n`/`m1_n`/`rfsh_n` strobes and serves reads from internal RAM or I/O registers onto `di`. It commits CPU writes exactly once per bus cycle and can stretch cycles through `wait_n`. It sits between `tv80s` and the rest of the system, replacing behavioural memory models in gate-level and FPGA builds. A side-band load port preloads RAM before or between CPU runs.

---
 rtl/z80_bus_pkg.sv | 32 +++
 rtl/z80_bus_decode.sv | 31 +++
 rtl/z80_bus_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the tv80s external-bus responder and any
// bus monitor that reuses the strobe classifier.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    HOLD
  } bus_state_e;

  typedef enum logic [2:0] {
    NONE,
    MEM_RD,
    MEM_WR,
    IO_RD,
    IO_WR,
    INTA
  } acc_class_e;

  localparam logic [7:0] INTA_VECTOR = 8'hFF;
  localparam logic [7:0] DI_RESET    = 8'hFF;

  function automatic logic is_read(input acc_class_e c);
    return c inside {MEM_RD, IO_RD, INTA};
  endfunction

  function automatic logic is_write(input acc_class_e c);
    return c inside {MEM_WR, IO_WR};
  endfunction

endpackage

// File: rtl/z80_bus_decode.sv
// Combinational classifier: tv80s bus strobes -> access class.
// Refresh (mreq_n=0, rfsh_n=0 with rd_n/wr_n high) classifies as NONE.
module z80_bus_decode
  import z80_bus_pkg::*;
(
  input  logic       mreq_n_i,
  input  logic       iorq_n_i,
  input  logic       rd_n_i,
  input  logic       wr_n_i,
  input  logic       m1_n_i,
  input  logic       rfsh_n_i,
  output acc_class_e acc_o
);

  // Priority-ordered strobe decode.
  always_comb begin
    acc_o = NONE;
    if (!mreq_n_i && !rd_n_i && rfsh_n_i) begin
      acc_o = MEM_RD;
    end else if (!mreq_n_i && !wr_n_i) begin
      acc_o = MEM_WR;
    end else if (!iorq_n_i && m1_n_i && !rd_n_i) begin
      acc_o = IO_RD;
    end else if (!iorq_n_i && m1_n_i && !wr_n_i) begin
      acc_o = IO_WR;
    end else if (!iorq_n_i && !m1_n_i) begin
      acc_o = INTA;
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Memory / I/O target for the tv80s external bus with a side-band RAM load
// port. Optional wait-state generator: define Z80_BUS_WAIT_GEN_EN.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned IO_DEPTH    = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       A,
  input  logic [7:0]        dout,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  input  logic              rfsh_n,
  output logic [7:0]        di,
  output logic              wait_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack
);

`ifdef Z80_BUS_WAIT_GEN_EN
  localparam bit WaitsOn = (WAIT_CYCLES != 0);
  localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`else
  // WAIT_CYCLES has no effect without the wait generator.
  localparam bit WaitsOn = 1'b0 && (WAIT_CYCLES != 0);
`endif

  logic [7:0] ram [2**ADDR_W];
  logic [7:0] io_mem [IO_DEPTH];

  bus_state_e  state_q, state_d;
  acc_class_e  acc_q, acc_d;
  acc_class_e  acc_now;
  logic [15:0] addr_q, addr_d;
  logic        written_q, written_d;
  logic [7:0]  di_q, di_d;
  logic        ld_ack_q, ld_ack_d;
`ifdef Z80_BUS_WAIT_GEN_EN
  logic [3:0]  wcnt_q, wcnt_d;
`endif

  logic              strobes_idle;
  logic              to_hold;
  logic              bus_we;
  logic              bus_mem_we;
  logic              bus_io_we;
  logic              ld_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic              io_hit;
  logic [7:0]        rd_data;

  z80_bus_decode u_decode (
    .mreq_n_i (mreq_n),
    .iorq_n_i (iorq_n),
    .rd_n_i   (rd_n),
    .wr_n_i   (wr_n),
    .m1_n_i   (m1_n),
    .rfsh_n_i (rfsh_n),
    .acc_o    (acc_now)
  );

  assign strobes_idle = mreq_n && iorq_n;
  assign io_hit       = (32'(addr_q[7:0]) < IO_DEPTH);

  // State register and per-cycle bookkeeping; memories are not reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= NONE;
      addr_q    <= '0;
      written_q <= 1'b0;
      di_q      <= DI_RESET;
      ld_ack_q  <= 1'b0;
`ifdef Z80_BUS_WAIT_GEN_EN
      wcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      written_q <= written_d;
      di_q      <= di_d;
      ld_ack_q  <= ld_ack_d;
`ifdef Z80_BUS_WAIT_GEN_EN
      wcnt_q    <= wcnt_d;
`endif
    end
  end

  // Next-state: latch class/address on decode, sequence waits, abort on release.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    written_d = written_q || bus_we;
    to_hold   = 1'b0;
`ifdef Z80_BUS_WAIT_GEN_EN
    wcnt_d    = wcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        written_d = 1'b0;
        if (acc_now != NONE) begin
          state_d = ACCESS;
          acc_d   = acc_now;
          addr_d  = A;
        end
      end
      ACCESS: begin
        if (strobes_idle) begin
          state_d = IDLE;
        end else if (WaitsOn) begin
`ifdef Z80_BUS_WAIT_GEN_EN
          state_d = WAIT;
          wcnt_d  = WaitLoad;
`endif
        end else begin
          to_hold = 1'b1;
        end
      end
      WAIT: begin
`ifdef Z80_BUS_WAIT_GEN_EN
        if (strobes_idle) begin
          state_d = IDLE;
        end else if (wcnt_q == '0) begin
          to_hold = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      HOLD: begin
        if (strobes_idle) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (to_hold) begin
      state_d = HOLD;
    end
  end

  // Outputs: single-commit write enables, load-port arbitration, read data.
  // Read data is captured on the HOLD transition rather than on ACCESS entry so
  // that di becomes valid exactly as wait_n releases the CPU.
  always_comb begin
    bus_we     = !reset && (state_q != IDLE) && is_write(acc_q) &&
                 !strobes_idle && !wr_n && !written_q;
    bus_mem_we = bus_we && (acc_q == MEM_WR);
    bus_io_we  = bus_we && (acc_q == IO_WR) && io_hit;
    ld_we      = !reset && ld_en && !bus_we;
    ld_ack_d   = ld_we;

    ram_we    = bus_mem_we || ld_we;
    ram_waddr = bus_mem_we ? addr_q[ADDR_W-1:0] : ld_addr;
    ram_wdata = bus_mem_we ? dout : ld_data;

    unique case (acc_q)
      MEM_RD:  rd_data = ram[addr_q[ADDR_W-1:0]];
      IO_RD:   rd_data = io_hit ? io_mem[addr_q[7:0]] : 8'hFF;
      INTA:    rd_data = INTA_VECTOR;
      default: rd_data = di_q;
    endcase

    di_d = di_q;
    if (to_hold && is_read(acc_q)) begin
      di_d = rd_data;
    end

`ifdef Z80_BUS_WAIT_GEN_EN
    wait_n = (state_q != WAIT);
`else
    wait_n = 1'b1;
`endif
  end

  // RAM and I/O register write ports.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
    if (bus_io_we) begin
      io_mem[addr_q[7:0]] <= dout;
    end
  end

  assign di     = di_q;
  assign ld_ack = ld_ack_q;

endmodule
